// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the sequential shift/rotate unit.
//   Opcodes (OP_*) are also consumed by the datapath control decoder.
//   State encoding (state_e) for the seq_shift_unit FSM.
//   op_legal(): true for the five supported shift/rotate opcodes.
package shift_pkg;

  localparam logic [4:0] OP_SHR  = 5'd5;  // logical right
  localparam logic [4:0] OP_SHRA = 5'd6;  // arithmetic right, sign fill
  localparam logic [4:0] OP_SHL  = 5'd7;  // left, zero fill
  localparam logic [4:0] OP_ROR  = 5'd8;  // rotate right
  localparam logic [4:0] OP_ROL  = 5'd9;  // rotate left

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [4:0] op);
    return (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-chunk shifter.
//   data_i    : WIDTH-bit value to move
//   op_i      : opcode (shift_pkg OP_*)
//   k_i       : bits to move this chunk, 0..STEP (SW bits wide, SW can hold WIDTH)
//   data_o    : shifted/rotated value (data_i unchanged for k_i=0 or unknown op)
//   out_bit_o : last bit moved out by this chunk, 0 when k_i=0
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 6
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [4:0]       op_i,
  input  logic [SW-1:0]    k_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  logic [SW-1:0]    k_m1;
  logic [SW-1:0]    k_inv;
  logic [WIDTH-1:0] rtmp;
  logic [WIDTH-1:0] ltmp;

  // The last bit moved out is the one sitting k-1 places from the exit end.
  assign k_m1  = k_i - SW'(1);
  assign k_inv = SW'(WIDTH) - k_i;
  assign rtmp  = data_i >> k_m1;
  assign ltmp  = data_i << k_m1;

  always_comb begin
    data_o    = data_i;
    out_bit_o = 1'b0;
    case (op_i)
      OP_SHR: begin
        data_o    = data_i >> k_i;
        out_bit_o = rtmp[0];
      end
      OP_SHRA: begin
        data_o    = $signed(data_i) >>> k_i;
        out_bit_o = rtmp[0];
      end
      OP_SHL: begin
        data_o    = data_i << k_i;
        out_bit_o = ltmp[WIDTH-1];
      end
      // k_inv = WIDTH when k_i = 0; a full-width shift yields 0, so no guard needed.
      OP_ROR: begin
        data_o    = (data_i >> k_i) | (data_i << k_inv);
        out_bit_o = rtmp[0];
      end
      OP_ROL: begin
        data_o    = (data_i << k_i) | (data_i >> k_inv);
        out_bit_o = ltmp[WIDTH-1];
      end
      default: begin
        data_o    = data_i;
        out_bit_o = 1'b0;
      end
    endcase
    if (k_i == '0) begin
      out_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit, STEP bits per cycle.
//   Clock   : rising-edge clock
//   Clear   : synchronous active-high reset, aborts any operation
//   start   : request, accepted only in IDLE
//   CONTROL : opcode, sampled on accept
//   A       : operand, sampled on accept
//   B       : shift amount, low log2(WIDTH) bits used, sampled on accept
//   busy    : high while shifting
//   done    : one-cycle pulse, result valid
//   err     : pulses with done for an illegal opcode
//   result  : shifted value, held until the next completion
//   carry   : last bit moved out, only when SEQ_SHIFT_CARRY_EN is defined
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | moving min(STEP, amt) bits per cycle
// S_DONE  | publish result/done/err on the next edge, then IDLE
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [4:0]       CONTROL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef SEQ_SHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  localparam int AW = $clog2(WIDTH);
  localparam int SW = AW + 1;  // wide enough to hold STEP (up to WIDTH)

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [AW-1:0]    amt_q;
  logic [AW-1:0]    amt_d;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             cout_q;

  logic [SW-1:0]    k_cur;
  logic [WIDTH-1:0] step_data;
  logic             step_out;
  logic [AW-1:0]    b_amt;
  logic             unused_b;

  assign b_amt    = B[AW-1:0];
  assign unused_b = ^B[WIDTH-1:AW];

  assign k_cur = (SW'(amt_q) > SW'(STEP)) ? SW'(STEP) : SW'(amt_q);
  assign amt_d = amt_q - AW'(k_cur);

  shift_step #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_step (
    .data_i    (work_q),
    .op_i      (op_q),
    .k_i       (k_cur),
    .data_o    (step_data),
    .out_bit_o (step_out)
  );

`ifdef SEQ_SHIFT_CARRY_EN
  logic carry_q;
  always_ff @(posedge Clock) begin
    if (Clear) begin
      carry_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      carry_q <= cout_q;
    end
  end
  assign carry = carry_q;
`else
  logic unused_cout;
  assign unused_cout = cout_q;
`endif

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      amt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            work_q <= A;
            amt_q  <= b_amt;
            op_q   <= CONTROL;
            // Cleared here so zero-amount and illegal ops report no carry.
            cout_q <= 1'b0;
            if (op_legal(CONTROL) && (b_amt != '0)) begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          work_q <= step_data;
          cout_q <= step_out;
          amt_q  <= amt_d;
          if (amt_d == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          result_q <= work_q;
          done_q   <= 1'b1;
          err_q    <= !op_legal(op_q);
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
